// File: rtl/ttt_token_inbuf_if.sv
// Token input buffer bus: external writes, recurrent network writes and the
// drain stream toward the processor core.
// master: token source / core side. slave: the buffer.
interface ttt_token_inbuf_if #(
    parameter int unsigned ID_BITS         = 4,
    parameter int unsigned NEW_TOKENS_BITS = 4
);
    logic                       ext_valid;
    logic                       ext_ready;
    logic [ID_BITS-1:0]         ext_id;
    logic [NEW_TOKENS_BITS-1:0] ext_good;
    logic [NEW_TOKENS_BITS-1:0] ext_bad;

    logic                       rec_valid;
    logic [ID_BITS-1:0]         rec_id;
    logic [NEW_TOKENS_BITS-1:0] rec_good;
    logic [NEW_TOKENS_BITS-1:0] rec_bad;

    logic                       out_valid;
    logic                       out_ready;
    logic [ID_BITS-1:0]         out_id;
    logic [NEW_TOKENS_BITS-1:0] out_good;
    logic [NEW_TOKENS_BITS-1:0] out_bad;
    logic                       out_last;

    modport master (
        output ext_valid, ext_id, ext_good, ext_bad,
        output rec_valid, rec_id, rec_good, rec_bad,
        output out_ready,
        input  ext_ready,
        input  out_valid, out_id, out_good, out_bad, out_last
    );

    modport slave (
        input  ext_valid, ext_id, ext_good, ext_bad,
        input  rec_valid, rec_id, rec_good, rec_bad,
        input  out_ready,
        output ext_ready,
        output out_valid, out_id, out_good, out_bad, out_last
    );
endinterface

// File: rtl/ttt_token_inbuf.sv
// Per-processor token input buffer: clears on INPUT entry, accumulates signed
// good/bad deltas during INPUT (external) and RECURRENT (network), and drains
// the entries in processor order to the core during UPDATE.
// Optional macro TTT_INBUF_SATURATE_EN: clamp accumulation and raise a sticky
// sat_flag; without it accumulation wraps and sat_flag stays 0.
module ttt_token_inbuf #(
    parameter int unsigned NUM_PROCESSORS  = 10,
    parameter int unsigned NEW_TOKENS_BITS = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [2:0]         stage,
    output logic               done,
    output logic               sat_flag,
    ttt_token_inbuf_if.slave   bus
);
    localparam int unsigned ID_BITS = (NUM_PROCESSORS > 1) ? $clog2(NUM_PROCESSORS) : 1;
    localparam int unsigned NB      = NEW_TOKENS_BITS;
    localparam logic [ID_BITS-1:0] LAST_ID = ID_BITS'(NUM_PROCESSORS - 1);

    localparam logic [2:0] STG_RESET     = 3'd0;
    localparam logic [2:0] STG_INPUT     = 3'd1;
    localparam logic [2:0] STG_RECURRENT = 3'd2;
    localparam logic [2:0] STG_UPDATE    = 3'd3;
    localparam logic [2:0] STG_OUTPUT    = 3'd4;

    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, FIN} state_t;

    state_t               state_q, state_d;
    logic [2:0]           stage_prev_q;
    logic                 stage_entry;
    logic [ID_BITS-1:0]   clr_idx_q, clr_idx_d;
    logic [NB-1:0]        cache_good_q [NUM_PROCESSORS];
    logic [NB-1:0]        cache_good_d [NUM_PROCESSORS];
    logic [NB-1:0]        cache_bad_q  [NUM_PROCESSORS];
    logic [NB-1:0]        cache_bad_d  [NUM_PROCESSORS];

    logic                 done_q, done_d;
    logic                 sat_q, sat_d;
    logic                 ext_ready_q, ext_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [ID_BITS-1:0]   out_id_q, out_id_d;
    logic [NB-1:0]        out_good_q, out_good_d;
    logic [NB-1:0]        out_bad_q, out_bad_d;
    logic                 out_last_q, out_last_d;

    logic                 wr_en;
    logic                 wr_hit;
    logic [ID_BITS-1:0]   wr_id;
    logic [ID_BITS-1:0]   wr_idx;
    logic [NB-1:0]        wr_good, wr_bad;
    logic [NB:0]          good_res, bad_res;
    logic                 drain_hs;

    // Signed add of a delta to an entry; MSB of the result flags a clamp.
    function automatic logic [NB:0] add_delta(input logic [NB-1:0] a, input logic [NB-1:0] b);
`ifdef TTT_INBUF_SATURATE_EN
        logic [NB:0] sum;
        sum = {a[NB-1], a} + {b[NB-1], b};
        if (sum[NB] != sum[NB-1]) begin
            // Top bit of the extended sum is the true sign: pick the rail.
            return sum[NB] ? {1'b1, 1'b1, {(NB-1){1'b0}}} : {1'b1, 1'b0, {(NB-1){1'b1}}};
        end
        return {1'b0, sum[NB-1:0]};
`else
        return {1'b0, a + b};
`endif
    endfunction

    assign stage_entry = (stage != stage_prev_q);

    // Select the single accumulation write for this cycle (ext or recurrent).
    always_comb begin
        wr_en   = 1'b0;
        wr_id   = '0;
        wr_good = '0;
        wr_bad  = '0;
        if (bus.ext_valid && ext_ready_q) begin
            wr_en   = 1'b1;
            wr_id   = bus.ext_id;
            wr_good = bus.ext_good;
            wr_bad  = bus.ext_bad;
        end else if (bus.rec_valid && stage == STG_RECURRENT &&
                     (state_q == ACCUM || state_q == IDLE || state_q == FIN)) begin
            wr_en   = 1'b1;
            wr_id   = bus.rec_id;
            wr_good = bus.rec_good;
            wr_bad  = bus.rec_bad;
        end
        // Out-of-range ids are consumed without touching any entry.
        wr_hit   = wr_en && (32'(wr_id) < NUM_PROCESSORS);
        wr_idx   = wr_hit ? wr_id : '0;
        good_res = add_delta(cache_good_q[wr_idx], wr_good);
        bad_res  = add_delta(cache_bad_q[wr_idx], wr_bad);
    end

    // Next state, cache update and registered-output values.
    always_comb begin
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
        out_id_d     = out_id_q;
        sat_d        = sat_q;
        cache_good_d = cache_good_q;
        cache_bad_d  = cache_bad_q;
        done_d       = 1'b0;
        ext_ready_d  = 1'b0;
        out_valid_d  = 1'b0;
        out_good_d   = '0;
        out_bad_d    = '0;
        out_last_d   = 1'b0;
        // An abort to RESET does not consume the entry on offer.
        drain_hs     = out_valid_q && bus.out_ready && (stage != STG_RESET);

        if (wr_hit) begin
            cache_good_d[wr_idx] = good_res[NB-1:0];
            cache_bad_d[wr_idx]  = bad_res[NB-1:0];
            sat_d                = sat_q | good_res[NB] | bad_res[NB];
        end

        case (state_q)
            IDLE, FIN: begin
                if (stage_entry) begin
                    case (stage)
                        STG_INPUT:     state_d = CLEAR;
                        STG_UPDATE:    state_d = DRAIN;
                        STG_RECURRENT: state_d = ACCUM;
                        default:       state_d = state_q;
                    endcase
                end
            end
            CLEAR: begin
                cache_good_d[clr_idx_q] = '0;
                cache_bad_d[clr_idx_q]  = '0;
                clr_idx_d               = clr_idx_q + ID_BITS'(1);
                if (clr_idx_q == LAST_ID) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (stage_entry) begin
                    case (stage)
                        STG_INPUT:  state_d = CLEAR;
                        STG_UPDATE: state_d = DRAIN;
                        STG_OUTPUT: state_d = IDLE;
                        default:    state_d = ACCUM;
                    endcase
                end
            end
            DRAIN: begin
                if (drain_hs) begin
                    cache_good_d[out_id_q] = '0;
                    cache_bad_d[out_id_q]  = '0;
                    if (out_id_q == LAST_ID) begin
                        state_d = FIN;
                    end else begin
                        out_id_d = out_id_q + ID_BITS'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (stage == STG_RESET) begin
            state_d = IDLE;
        end

        if (state_d == CLEAR && state_q != CLEAR) begin
            clr_idx_d = '0;
            sat_d     = 1'b0;
        end

        if (state_d != DRAIN || state_q != DRAIN) begin
            out_id_d = (state_d == DRAIN && state_q == DRAIN) ? out_id_d : '0;
        end

        case (state_d)
            IDLE:  done_d = (stage == STG_RESET) || (stage == STG_OUTPUT);
            ACCUM: begin
                done_d      = 1'b1;
                ext_ready_d = (stage == STG_INPUT);
            end
            DRAIN: begin
                out_valid_d = 1'b1;
                out_good_d  = cache_good_d[out_id_d];
                out_bad_d   = cache_bad_d[out_id_d];
                out_last_d  = (out_id_d == LAST_ID);
            end
            FIN:   done_d = 1'b1;
            default: done_d = 1'b0;
        endcase
    end

    // State, cache and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            stage_prev_q <= STG_RESET;
            clr_idx_q    <= '0;
            cache_good_q <= '{default: '0};
            cache_bad_q  <= '{default: '0};
            done_q       <= 1'b0;
            sat_q        <= 1'b0;
            ext_ready_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_id_q     <= '0;
            out_good_q   <= '0;
            out_bad_q    <= '0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            stage_prev_q <= stage;
            clr_idx_q    <= clr_idx_d;
            cache_good_q <= cache_good_d;
            cache_bad_q  <= cache_bad_d;
            done_q       <= done_d;
            sat_q        <= sat_d;
            ext_ready_q  <= ext_ready_d;
            out_valid_q  <= out_valid_d;
            out_id_q     <= out_id_d;
            out_good_q   <= out_good_d;
            out_bad_q    <= out_bad_d;
            out_last_q   <= out_last_d;
        end
    end

    assign done          = done_q;
    assign sat_flag      = sat_q;
    assign bus.ext_ready = ext_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_id    = out_id_q;
    assign bus.out_good  = out_good_q;
    assign bus.out_bad   = out_bad_q;
    assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_ttt_token_inbuf.sv
// Directed bench for ttt_token_inbuf (N=10, B=4) with hand-computed expectations.
module tb_ttt_token_inbuf;
    localparam int N = 10;

    localparam logic [2:0] STG_RESET     = 3'd0;
    localparam logic [2:0] STG_INPUT     = 3'd1;
    localparam logic [2:0] STG_RECURRENT = 3'd2;
    localparam logic [2:0] STG_UPDATE    = 3'd3;

    logic       clk;
    logic       reset_n;
    logic [2:0] stage;
    logic       done;
    logic       sat_flag;

    ttt_token_inbuf_if #(.ID_BITS(4), .NEW_TOKENS_BITS(4)) bus ();

    ttt_token_inbuf #(.NUM_PROCESSORS(10), .NEW_TOKENS_BITS(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .stage    (stage),
        .done     (done),
        .sat_flag (sat_flag),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int exp_good [N];
    int exp_bad  [N];

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int s4(input logic [3:0] v);
        return int'($signed(v));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_exp();
        for (int i = 0; i < N; i++) begin
            exp_good[i] = 0;
            exp_bad[i]  = 0;
        end
    endtask

    // Enter INPUT and count cycles with done low until the clear finishes.
    task automatic enter_input(output int low);
        stage = STG_INPUT;
        low = 0;
        tick();
        while (!done && low < 50) begin
            low++;
            tick();
        end
    endtask

    task automatic ext_write(input int id, input int g, input int b);
        bus.ext_valid = 1'b1;
        bus.ext_id    = 4'(id);
        bus.ext_good  = 4'(g);
        bus.ext_bad   = 4'(b);
        tick();
        bus.ext_valid = 1'b0;
    endtask

    // Enter UPDATE with out_ready high and compare every drained entry.
    task automatic drain_all(input string tag);
        stage = STG_UPDATE;
        bus.out_ready = 1'b1;
        tick();
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_valid%0d", tag, i), int'(bus.out_valid), 1);
            check($sformatf("%s_id%0d", tag, i), int'(bus.out_id), i);
            check($sformatf("%s_good%0d", tag, i), s4(bus.out_good), exp_good[i]);
            check($sformatf("%s_bad%0d", tag, i), s4(bus.out_bad), exp_bad[i]);
            check($sformatf("%s_last%0d", tag, i), int'(bus.out_last), (i == N - 1) ? 1 : 0);
            tick();
        end
        check($sformatf("%s_fin_done", tag), int'(done), 1);
        check($sformatf("%s_fin_valid", tag), int'(bus.out_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int low;
        int cnt;
        clk           = 1'b0;
        reset_n       = 1'b0;
        stage         = STG_RESET;
        bus.ext_valid = 1'b0;
        bus.ext_id    = '0;
        bus.ext_good  = '0;
        bus.ext_bad   = '0;
        bus.rec_valid = 1'b0;
        bus.rec_id    = '0;
        bus.rec_good  = '0;
        bus.rec_bad   = '0;
        bus.out_ready = 1'b0;

        // Reset state.
        #1;
        check("rst_done", int'(done), 0);
        check("rst_valid", int'(bus.out_valid), 0);
        check("rst_ready", int'(bus.ext_ready), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        check("idle_done", int'(done), 1);

        // Clear, back-to-back accumulate to id3, drain.
        enter_input(low);
        check("clr_cycles", low, 10);
        check("accum_ready", int'(bus.ext_ready), 1);
        check("accum_done", int'(done), 1);
        ext_write(3, 5, -2);
        ext_write(3, 1, 0);
        clear_exp();
        exp_good[3] = 6;
        exp_bad[3]  = -2;
        drain_all("cad");

        // Overflow: 7 + 7.
        enter_input(low);
        ext_write(0, 7, 0);
        ext_write(0, 7, 0);
        clear_exp();
`ifdef TTT_INBUF_SATURATE_EN
        exp_good[0] = 7;
        check("ovf_sat", int'(sat_flag), 1);
`else
        exp_good[0] = -2;
        check("ovf_sat", int'(sat_flag), 0);
`endif
        drain_all("ovf");

        // Backpressure at id5.
        enter_input(low);
        check("bp_sat_cleared", int'(sat_flag), 0);
        ext_write(5, 2, -1);
        ext_write(6, 3, 4);
        stage = STG_UPDATE;
        bus.out_ready = 1'b1;
        tick();
        repeat (5) tick();
        check("bp_at5", int'(bus.out_id), 5);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("bp_hold_id%0d", k), int'(bus.out_id), 5);
            check($sformatf("bp_hold_good%0d", k), s4(bus.out_good), 2);
            check($sformatf("bp_hold_bad%0d", k), s4(bus.out_bad), -1);
            check($sformatf("bp_hold_valid%0d", k), int'(bus.out_valid), 1);
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_resume_id", int'(bus.out_id), 6);
        check("bp_resume_good", s4(bus.out_good), 3);
        check("bp_resume_bad", s4(bus.out_bad), 4);
        cnt = 0;
        while (!done && cnt < 20) begin
            tick();
            cnt++;
        end
        check("bp_tail_cycles", cnt, 4);

        // Out-of-range external write, then recurrent write.
        enter_input(low);
        ext_write(12, 3, 3);
        stage         = STG_RECURRENT;
        bus.rec_valid = 1'b1;
        bus.rec_id    = 4'd2;
        bus.rec_good  = 4'(-3);
        bus.rec_bad   = 4'd1;
        tick();
        bus.rec_valid = 1'b0;
        check("rec_ready", int'(bus.ext_ready), 0);
        check("rec_done", int'(done), 1);
        bus.ext_valid = 1'b1;
        bus.ext_id    = 4'd7;
        bus.ext_good  = 4'd1;
        bus.ext_bad   = 4'd1;
        tick();
        tick();
        check("rec_ready_held", int'(bus.ext_ready), 0);
        bus.ext_valid = 1'b0;
        clear_exp();
        exp_good[2] = -3;
        exp_bad[2]  = 1;
        drain_all("rec");

        // Abort a drain at id4, then re-drain.
        enter_input(low);
        for (int i = 0; i < N; i++) begin
            ext_write(i, 5 - i, 1);
        end
        stage = STG_UPDATE;
        bus.out_ready = 1'b1;
        tick();
        repeat (4) tick();
        check("abort_at4", int'(bus.out_id), 4);
        check("abort_good4", s4(bus.out_good), 1);
        stage = STG_RESET;
        tick();
        check("abort_valid", int'(bus.out_valid), 0);
        check("abort_ready", int'(bus.ext_ready), 0);
        check("abort_done", int'(done), 1);
        for (int i = 0; i < N; i++) begin
            exp_good[i] = (i < 4) ? 0 : 5 - i;
            exp_bad[i]  = (i < 4) ? 0 : 1;
        end
        drain_all("redrain");

        // Mid-cycle reset during a drain zeroes outputs and the cache.
        enter_input(low);
        ext_write(8, 4, 4);
        stage = STG_UPDATE;
        bus.out_ready = 1'b1;
        tick();
        tick();
        #3 reset_n = 1'b0;
        #1;
        check("mrst_valid", int'(bus.out_valid), 0);
        check("mrst_done", int'(done), 0);
        check("mrst_ready", int'(bus.ext_ready), 0);
        check("mrst_sat", int'(sat_flag), 0);
        check("mrst_id", int'(bus.out_id), 0);
        stage = STG_RESET;
        #2 reset_n = 1'b1;
        tick();
        check("mrst_idle_done", int'(done), 1);
        clear_exp();
        drain_all("mrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
